// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Desc     : ID/EX pipeline register with load-use hazard detection.
//             Stalls PC and IF/ID and inserts a bubble when a load in EX
//             feeds the instruction in ID; honours branch flushes from EX.
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [8:0]        id_ctrl,
  input  logic              id_valid,
  input  logic              flush,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [8:0]        ex_ctrl,
  output logic              ex_valid,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  stall_count
);

  // Position of MemRead inside the control bundle.
  localparam int             c_MEMREAD_BIT = 7;
  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0]        ex_rs_q, ex_rs_d;
  logic [4:0]        ex_rt_q, ex_rt_d;
  logic [4:0]        ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0] ex_rdata1_q, ex_rdata1_d;
  logic [DATA_W-1:0] ex_rdata2_q, ex_rdata2_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [8:0]        ex_ctrl_q, ex_ctrl_d;
  logic              ex_valid_q, ex_valid_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic w_hz;
  logic w_stall;
  logic w_bubble;

  // Load-use detection: only registered EX state and ID inputs are used, so
  // a bubble in EX (valid = 0, ctrl = 0) can never re-trigger a stall.
  always_comb begin
    w_hz = ex_ctrl_q[c_MEMREAD_BIT] & ex_valid_q & (ex_rt_q != 5'd0) & id_valid &
           ((id_uses_rs & (ex_rt_q == id_rs)) | (id_uses_rt & (ex_rt_q == id_rt)));
    // A wrong-path instruction being flushed must not hold the front end.
    w_stall  = w_hz & ~flush;
    w_bubble = flush | w_stall;
  end

  // Next-state for the pipeline register and the saturating stall counter.
  always_comb begin
    ex_rs_d       = id_rs;
    ex_rt_d       = id_rt;
    ex_rd_d       = id_rd;
    ex_rdata1_d   = id_rdata1;
    ex_rdata2_d   = id_rdata2;
    ex_imm_d      = id_imm;
    ex_ctrl_d     = id_valid ? id_ctrl : 9'd0;
    ex_valid_d    = id_valid;
    stall_count_d = stall_count_q;
    if (w_bubble) begin
      // Zeroed specifiers keep the forwarding comparators from matching a bubble.
      ex_rs_d    = 5'd0;
      ex_rt_d    = 5'd0;
      ex_rd_d    = 5'd0;
      ex_ctrl_d  = 9'd0;
      ex_valid_d = 1'b0;
    end
    if (w_stall && (stall_count_q != c_CNT_MAX)) begin
      stall_count_d = stall_count_q + c_CNT_ONE;
    end
  end

  // ID/EX state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_q       <= 5'd0;
      ex_rt_q       <= 5'd0;
      ex_rd_q       <= 5'd0;
      ex_rdata1_q   <= '0;
      ex_rdata2_q   <= '0;
      ex_imm_q      <= '0;
      ex_ctrl_q     <= 9'd0;
      ex_valid_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_rd_q       <= ex_rd_d;
      ex_rdata1_q   <= ex_rdata1_d;
      ex_rdata2_q   <= ex_rdata2_d;
      ex_imm_q      <= ex_imm_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_valid_q    <= ex_valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rdata1   = ex_rdata1_q;
  assign ex_rdata2   = ex_rdata2_q;
  assign ex_imm      = ex_imm_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_valid    = ex_valid_q;
  assign stall_count = stall_count_q;
  assign pc_write    = ~w_stall;
  assign if_id_write = ~w_stall;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Desc     : Directed self-checking bench for id_ex_stage (CNT_W = 2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 2;

  // Control encodings {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch, ALUOp}
  localparam logic [8:0] c_LW  = 9'h1B0;
  localparam logic [8:0] c_ADD = 9'h10A;
  localparam logic [8:0] c_SW  = 9'h050;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          id_uses_rs, id_uses_rt;
  logic [DW-1:0] id_rdata1, id_rdata2, id_imm;
  logic [8:0]    id_ctrl;
  logic          id_valid, flush;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm;
  logic [8:0]    ex_ctrl;
  logic          ex_valid, pc_write, if_id_write;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_valid(id_valid), .flush(flush),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one decoded instruction in ID.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic urs, input logic urt, input logic [8:0] ctrl);
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_uses_rs = urs;
    id_uses_rt = urt;
    id_ctrl    = ctrl;
    id_valid   = 1'b1;
    id_rdata1  = 32'hA000_0000 | {27'd0, rs};
    id_rdata2  = 32'hB000_0000 | {27'd0, rt};
    id_imm     = 32'hC000_0000 | {27'd0, rd};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [CW-1:0] exp_sat [5];

  initial begin
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3;
    exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;

    // Reset held with random inputs.
    rst_n      = 1'b0;
    flush      = 1'b0;
    id_rs      = 5'($urandom);
    id_rt      = 5'($urandom);
    id_rd      = 5'($urandom);
    id_uses_rs = 1'($urandom);
    id_uses_rt = 1'($urandom);
    id_rdata1  = $urandom;
    id_rdata2  = $urandom;
    id_imm     = $urandom;
    id_ctrl    = 9'($urandom);
    id_valid   = 1'b1;
    repeat (3) tick();
    check("rst_ctrl", 32'(ex_ctrl), 32'd0);
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_rdata1", ex_rdata1, 32'd0);
    check("rst_cnt", 32'(stall_count), 32'd0);
    check("rst_pcw", 32'(pc_write), 32'd1);

    @(negedge clk);
    rst_n = 1'b1;
    drive(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 9'h100);
    #1;
    check("rel_rd_hold", 32'(ex_rd), 32'd0);
    tick();
    check("cap_rd", 32'(ex_rd), 32'd5);
    check("cap_ctrl", 32'(ex_ctrl), 32'h100);
    check("cap_valid", 32'(ex_valid), 32'd1);

    // Load-use: lw rt=8 into EX, then add rs=8 in ID.
    drive(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, c_LW);
    tick();
    drive(5'd8, 5'd3, 5'd10, 1'b1, 1'b1, c_ADD);
    #1;
    check("lu_pcw", 32'(pc_write), 32'd0);
    check("lu_ifid", 32'(if_id_write), 32'd0);
    check("lu_no_comb_path", 32'(ex_rs), 32'd1);
    tick();
    check("lu_bub_ctrl", 32'(ex_ctrl), 32'd0);
    check("lu_bub_valid", 32'(ex_valid), 32'd0);
    check("lu_bub_rt", 32'(ex_rt), 32'd0);
    check("lu_cnt", 32'(stall_count), 32'd1);
    check("lu_pcw_after", 32'(pc_write), 32'd1);
    tick();
    check("lu_cap_rs", 32'(ex_rs), 32'd8);
    check("lu_cap_ctrl", 32'(ex_ctrl), 32'(c_ADD));
    check("lu_cap_rdata1", ex_rdata1, 32'hA000_0008);
    check("lu_cap_valid", 32'(ex_valid), 32'd1);
    check("lu_cnt_hold", 32'(stall_count), 32'd1);

    // No false stall: rt matches but is not read.
    drive(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, c_LW);
    tick();
    drive(5'd9, 5'd8, 5'd0, 1'b1, 1'b0, c_SW);
    #1;
    check("nfs_uses_rt0", 32'(pc_write), 32'd1);
    tick();
    check("nfs_cap_ctrl", 32'(ex_ctrl), 32'(c_SW));
    // No stall on $0 destination.
    drive(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, c_LW);
    tick();
    drive(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, c_ADD);
    #1;
    check("nfs_rt_zero", 32'(pc_write), 32'd1);
    check("nfs_cnt", 32'(stall_count), 32'd1);

    // Flush has priority over stall.
    tick();
    drive(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, c_LW);
    tick();
    drive(5'd8, 5'd3, 5'd10, 1'b1, 1'b1, c_ADD);
    flush = 1'b1;
    #1;
    check("fl_pcw", 32'(pc_write), 32'd1);
    check("fl_ifid", 32'(if_id_write), 32'd1);
    tick();
    flush = 1'b0;
    check("fl_ctrl", 32'(ex_ctrl), 32'd0);
    check("fl_valid", 32'(ex_valid), 32'd0);
    check("fl_rd", 32'(ex_rd), 32'd0);
    check("fl_cnt", 32'(stall_count), 32'd1);

    // Asynchronous reset in the middle of a stall cycle.
    drive(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, c_LW);
    tick();
    drive(5'd8, 5'd3, 5'd10, 1'b1, 1'b1, c_ADD);
    #1;
    check("ar_pcw_pre", 32'(pc_write), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_pcw", 32'(pc_write), 32'd1);
    check("ar_ctrl", 32'(ex_ctrl), 32'd0);
    check("ar_rt", 32'(ex_rt), 32'd0);
    check("ar_cnt", 32'(stall_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation: five separate load-use stalls with a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      drive(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, c_LW);
      tick();
      drive(5'd2, 5'd8, 5'd11, 1'b0, 1'b1, c_ADD);
      tick();
      check($sformatf("sat_%0d", i), 32'(stall_count), 32'(exp_sat[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage pipelined MIPS core. It captures decoded operands, register specifiers and control bits at the end of ID. It presents them to EX, where ex_rs/ex_rt feed the forwarding unit's Rs/Rt comparators. It also stalls PC and IF/ID, inserts a bubble when a load in EX feeds the instruction in ID, and honours branch flushes from EX.

## Interface
Parameters:
- DATA_W, 32, operand/immediate width
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs, id_rt, id_rd  in  5 each  register specifiers from decode
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads rs/rt
- id_rdata1, id_rdata2  in  DATA_W each  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  9  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch, ALUOp[1:0]}, bit 8 = RegWrite
- id_valid  in  1  IF/ID holds a real instruction
- flush  in  1  branch taken in EX; squash the ID instruction
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers
- ex_rdata1, ex_rdata2, ex_imm  out  DATA_W each  registered operands
- ex_ctrl  out  9  registered control, same bit order
- ex_valid  out  1  EX holds a real instruction
- pc_write  out  1  PC update enable (0 = hold)
- if_id_write  out  1  IF/ID load enable (0 = hold)
- stall_count  out  CNT_W  number of load-use stall cycles, saturating

## Operation
- Hazard (combinational from registered EX state plus ID inputs): hz = ex_ctrl[MemRead] & ex_valid & (ex_rt != 0) & id_valid & ((id_uses_rs & ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- stall = hz & ~flush. pc_write = if_id_write = ~stall.
- Every rising edge, unless in reset:
  - If flush or stall: load a bubble. ex_ctrl = 0 and ex_valid = 0. ex_rs/ex_rt/ex_rd are forced to 0, so the forwarding comparators never match a bubble. Data fields load ID values (don't-care).
  - Otherwise: load all id_* fields, with ex_valid = id_valid. When id_valid = 0, ex_ctrl is loaded as 0.
- Flush has priority over stall. A wrong-path instruction never causes a stall.
- stall_count increments by 1 on each edge where stall = 1. It holds at 2^CNT_W−1 and never wraps.
- A bubble clears MemRead in EX, so a stall lasts exactly one cycle per load-use pair.
- Register $0 as ex_rt never causes a stall.

## Timing
- Latency: id_* to ex_* is 1 cycle.
- Reset (asynchronous, rst_n = 0): all ex_* = 0, ex_valid = 0, stall_count = 0. pc_write = if_id_write = 1, because hz = 0 when ex_valid = 0.
- Reset deasserts synchronously to clk. The first capture happens on the first rising edge with rst_n = 1.
- Reset asserted mid-stall: outputs clear immediately, and pc_write returns to 1 in the same cycle.
- pc_write and if_id_write are combinational and valid before the edge that would otherwise advance IF/ID. The instruction held in ID is re-presented the next cycle and then captured normally. The forwarding unit then selects MEM/WB data for it.
- No combinational path exists from id_* to ex_*.

## Test plan
- Reset: hold rst_n = 0 with random inputs, then release → all ex_* = 0, ex_valid = 0, stall_count = 0, pc_write = 1. Next edge captures id_rd = 5, id_ctrl = 9'h100.
- Load-use: EX holds lw with rt = 8; ID holds add with rs = 8, uses_rs = 1 → pc_write = 0 and if_id_write = 0 for exactly one cycle. Next ex_ctrl = 0, ex_valid = 0, stall_count = 1. The following cycle captures add with ex_rs = 8.
- No false stall: lw rt = 8 in EX; ID reads rt = 8 but uses_rt = 0 (e.g. sw base only via rs = 9) → pc_write stays 1. Same check with lw rt = 0 → no stall.
- Flush priority: load-use condition present and flush = 1 → pc_write = 1, bubble loaded, stall_count unchanged.
- Saturation: with CNT_W = 2, force 5 stall cycles → stall_count reads 1, 2, 3, 3, 3.
- Async reset during stall: assert rst_n mid-cycle while pc_write = 0 → pc_write = 1 and ex_ctrl = 0 without waiting for a clock edge.
